cond_exec_stage: RTL and testbench

Decode-to-execute pipeline register plus ARM-style conditional-execution logic, placed directly downstream of the control unit. It captures the control word and condition field of each decoded instruction and holds the NZCV flag register. It evaluates the condition against the flags and presents the gated write-enables and branch/PC-select outputs to the execute, memory and writeback stages.

---
 rtl/cond_pkg.sv | 47 ++++
 rtl/cond_check.sv | 40 ++++
 rtl/cond_exec_stage.sv | 118 +++++++++++
 tb/tb_cond_exec_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution stage: condition codes, NZCV flag layout
// and the E-stage control word.
package cond_pkg;

    localparam int FLAGS_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'ha,
        COND_LT = 4'hb,
        COND_GT = 4'hc,
        COND_LE = 4'hd,
        COND_AL = 4'he,
        COND_NV = 4'hf
    } cond_e;

    typedef logic [FLAGS_W-1:0] flags_t;

    typedef struct packed {
        logic       valid;
        cond_e      cond;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       nowrite;
        logic [1:0] flagw;
        logic [3:0] alucontrol;
    } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: condition field against NZCV flags.
// Shared with branch prediction, so it holds no state.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: the default arm assigns pass on every path, so no latch is inferred.
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Decode-to-execute register with NZCV flags and condition-gated enables.
// Optional SQUASH_CNT_EN adds a saturating count of condition-failed instructions.
module cond_exec_stage
    import cond_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic [3:0]          CondD,
    input  logic                PCSD,
    input  logic                RegWD,
    input  logic                MemWD,
    input  logic                MemtoRegD,
    input  logic                ALUSrcD,
    input  logic                BranchD,
    input  logic                NoWriteD,
    input  logic [1:0]          FlagWD,
    input  logic [3:0]          ALUControlD,
    input  logic [FLAGS_W-1:0]  ALUFlagsE,
`ifdef SQUASH_CNT_EN
    input  logic                SquashClr,
    output logic [15:0]         SquashCnt,
`endif
    output logic [3:0]          ALUControlE,
    output logic                ALUSrcE,
    output logic                MemtoRegE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic                PCSrcE,
    output logic                BranchTakenE,
    output logic                CondExE,
    output logic [FLAGS_W-1:0]  FlagsQ
);

    ctrl_t  ctrl_d;
    ctrl_t  ctrl_q;
    flags_t flags_q;
    logic   cond_pass;
    logic   cond_ex;
    logic   flag_en;

    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = 1'b1;
        ctrl_d.cond       = cond_e'(CondD);
        ctrl_d.pcs        = PCSD;
        ctrl_d.regw       = RegWD;
        ctrl_d.memw       = MemWD;
        ctrl_d.memtoreg   = MemtoRegD;
        ctrl_d.alusrc     = ALUSrcD;
        ctrl_d.branch     = BranchD;
        ctrl_d.nowrite    = NoWriteD;
        ctrl_d.flagw      = FlagWD;
        ctrl_d.alucontrol = ALUControlD;
    end

    // NOTE: sequential state uses non-blocking assignments and an async reset on every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (FlushE) begin
            ctrl_q <= '0;
        end else if (!StallE) begin
            ctrl_q <= ctrl_d;
        end
    end

    cond_check u_cond_check (
        .cond  (ctrl_q.cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    assign cond_ex = ctrl_q.valid & cond_pass;

    // A flush retires the E instruction's flag write even when a stall is also requested.
    assign flag_en = cond_ex & (~StallE | FlushE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (flag_en) begin
            if (ctrl_q.flagw[1]) flags_q[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
            if (ctrl_q.flagw[0]) flags_q[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
        end
    end

`ifdef SQUASH_CNT_EN
    logic [15:0] squash_cnt_q;
    logic        squash;

    assign squash = ctrl_q.valid & ~cond_pass & ~StallE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_cnt_q <= '0;
        end else if (SquashClr) begin
            squash_cnt_q <= '0;
        end else if (squash && (squash_cnt_q != 16'hffff)) begin
            squash_cnt_q <= squash_cnt_q + 16'd1;
        end
    end

    assign SquashCnt = squash_cnt_q;
`endif

    assign CondExE      = cond_ex;
    assign RegWriteE    = ctrl_q.regw & cond_ex & ~ctrl_q.nowrite;
    assign MemWriteE    = ctrl_q.memw & cond_ex;
    assign PCSrcE       = ctrl_q.pcs & cond_ex;
    assign BranchTakenE = ctrl_q.branch & cond_ex;
    assign ALUControlE  = ctrl_q.alucontrol;
    assign ALUSrcE      = ctrl_q.alusrc;
    assign MemtoRegE    = ctrl_q.memtoreg;
    assign FlagsQ       = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed-vector bench for cond_exec_stage; squash-counter scenarios build with SQUASH_CNT_EN.
module tb_cond_exec_stage;

    logic       clk;
    logic       rst_n;
    logic       StallE, FlushE;
    logic [3:0] CondD;
    logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD;
    logic [1:0] FlagWD;
    logic [3:0] ALUControlD;
    logic [3:0] ALUFlagsE;
    logic [3:0] ALUControlE;
    logic       ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE;
    logic [3:0] FlagsQ;
`ifdef SQUASH_CNT_EN
    logic        SquashClr;
    logic [15:0] SquashCnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // {ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE, FlagsQ}
    logic [14:0] obs;
    assign obs = {ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE,
                  PCSrcE, BranchTakenE, CondExE, FlagsQ};

    cond_exec_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .CondD        (CondD),
        .PCSD         (PCSD),
        .RegWD        (RegWD),
        .MemWD        (MemWD),
        .MemtoRegD    (MemtoRegD),
        .ALUSrcD      (ALUSrcD),
        .BranchD      (BranchD),
        .NoWriteD     (NoWriteD),
        .FlagWD       (FlagWD),
        .ALUControlD  (ALUControlD),
        .ALUFlagsE    (ALUFlagsE),
`ifdef SQUASH_CNT_EN
        .SquashClr    (SquashClr),
        .SquashCnt    (SquashCnt),
`endif
        .ALUControlE  (ALUControlE),
        .ALUSrcE      (ALUSrcE),
        .MemtoRegE    (MemtoRegE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .PCSrcE       (PCSrcE),
        .BranchTakenE (BranchTakenE),
        .CondExE      (CondExE),
        .FlagsQ       (FlagsQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cond, input logic pcs, input logic regw,
                         input logic memw, input logic memtoreg, input logic alusrc,
                         input logic branch, input logic nowrite, input logic [1:0] flagw,
                         input logic [3:0] aluctl);
        CondD       = cond;
        PCSD        = pcs;
        RegWD       = regw;
        MemWD       = memw;
        MemtoRegD   = memtoreg;
        ALUSrcD     = alusrc;
        BranchD     = branch;
        NoWriteD    = nowrite;
        FlagWD      = flagw;
        ALUControlD = aluctl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        ALUFlagsE = 4'hf;
`ifdef SQUASH_CNT_EN
        SquashClr = 1'b0;
`endif
        drive(4'he, 1, 1, 1, 1, 1, 1, 0, 2'b11, 4'hf);
        tick();
        tick();
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_hold obs=%b expected=%b", obs, 15'd0);
        end
`ifdef SQUASH_CNT_EN
        vectors++;
        if (SquashCnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got=%h expected=0000", SquashCnt);
        end
`endif
        drive(4'he, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h7);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_release obs=%b expected=%b", obs, 15'd0);
        end
        tick();
        vectors++;
        if (obs !== 15'b0111_0_0_1_0_0_0_1_0000) begin
            miscompares++;
            $display("FAIL first_capture obs=%b expected=%b", obs, 15'b0111_0_0_1_0_0_0_1_0000);
        end
    endtask

    task automatic test_eq_ne();
        drive(4'he, 0, 1, 0, 0, 0, 0, 0, 2'b11, 4'h2);
        tick();
        ALUFlagsE = 4'b0100;
        vectors++;
        if ({RegWriteE, CondExE, FlagsQ} !== 6'b11_0000) begin
            miscompares++;
            $display("FAIL subs_in_e got=%b expected=%b", {RegWriteE, CondExE, FlagsQ}, 6'b11_0000);
        end
        drive(4'h0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h4);
        tick();
        ALUFlagsE = 4'b1111;
        vectors++;
        if ({RegWriteE, FlagsQ} !== 5'b1_0100) begin
            miscompares++;
            $display("FAIL eq_pass got=%b expected=%b", {RegWriteE, FlagsQ}, 5'b1_0100);
        end
        drive(4'h1, 0, 1, 0, 0, 0, 0, 0, 2'b11, 4'h4);
        tick();
        vectors++;
        if ({RegWriteE, CondExE, FlagsQ} !== 6'b00_0100) begin
            miscompares++;
            $display("FAIL ne_fail got=%b expected=%b", {RegWriteE, CondExE, FlagsQ}, 6'b00_0100);
        end
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if (FlagsQ !== 4'b0100) begin
            miscompares++;
            $display("FAIL failed_cond_flags got=%b expected=0100", FlagsQ);
        end
    endtask

    task automatic test_cmp_branch();
        drive(4'he, 0, 1, 0, 0, 0, 0, 1, 2'b11, 4'h2);
        tick();
        ALUFlagsE = 4'b1000;
        vectors++;
        if ({RegWriteE, CondExE, FlagsQ} !== 6'b01_0100) begin
            miscompares++;
            $display("FAIL cmp_nowrite got=%b expected=%b", {RegWriteE, CondExE, FlagsQ}, 6'b01_0100);
        end
        drive(4'hb, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if ({BranchTakenE, FlagsQ} !== 5'b1_1000) begin
            miscompares++;
            $display("FAIL lt_taken got=%b expected=%b", {BranchTakenE, FlagsQ}, 5'b1_1000);
        end
        drive(4'ha, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if ({BranchTakenE, CondExE} !== 2'b00) begin
            miscompares++;
            $display("FAIL ge_not_taken got=%b expected=00", {BranchTakenE, CondExE});
        end
    endtask

    // mask bit i is the expected pass for condition code i under flags fv.
    task automatic test_cond_table(input logic [3:0] fv, input logic [15:0] mask);
        logic p;
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'h0);
        tick();
        ALUFlagsE = fv;
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 0, 0, 1, 1, 1, 0, 0, 2'b00, 4'h0);
            tick();
            p = mask[i];
            vectors++;
            if ({MemWriteE, CondExE, ALUSrcE, MemtoRegE} !== {p, p, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL cond_table flags=%b cond=%0d got=%b expected=%b",
                         fv, i, {MemWriteE, CondExE, ALUSrcE, MemtoRegE}, {p, p, 1'b1, 1'b1});
            end
        end
        vectors++;
        if (FlagsQ !== fv) begin
            miscompares++;
            $display("FAIL cond_table_flags got=%b expected=%b", FlagsQ, fv);
        end
    endtask

    task automatic test_partial_flags();
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b10, 4'h0);
        tick();
        ALUFlagsE = 4'b1100;
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b01, 4'h0);
        tick();
        ALUFlagsE = 4'b0000;
        vectors++;
        if (FlagsQ !== 4'b1111) begin
            miscompares++;
            $display("FAIL nz_only got=%b expected=1111", FlagsQ);
        end
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if (FlagsQ !== 4'b1100) begin
            miscompares++;
            $display("FAIL cv_only got=%b expected=1100", FlagsQ);
        end
    endtask

    task automatic test_stall_flush();
        drive(4'he, 0, 1, 0, 0, 0, 0, 0, 2'b11, 4'h5);
        tick();
        ALUFlagsE = 4'b0010;
        StallE = 1'b1;
        drive(4'h0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h9);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== 15'b0101_0_0_1_0_0_0_1_1100) begin
                miscompares++;
                $display("FAIL stall_hold cycle=%0d obs=%b expected=%b",
                         i, obs, 15'b0101_0_0_1_0_0_0_1_1100);
            end
        end
        StallE = 1'b0;
        tick();
        vectors++;
        if (obs !== 15'b1001_0_0_0_0_0_0_0_0010) begin
            miscompares++;
            $display("FAIL stall_release obs=%b expected=%b", obs, 15'b1001_0_0_0_0_0_0_0_0010);
        end
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'h3);
        tick();
        ALUFlagsE = 4'b0101;
        StallE = 1'b1;
        FlushE = 1'b1;
        tick();
        vectors++;
        if (obs !== 15'b0000_0_0_0_0_0_0_0_0101) begin
            miscompares++;
            $display("FAIL flush_stall obs=%b expected=%b", obs, 15'b0000_0_0_0_0_0_0_0_0101);
        end
        StallE = 1'b0;
        FlushE = 1'b0;
        ALUFlagsE = 4'b1111;
        drive(4'he, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if (obs !== 15'b0000_0_0_1_0_0_0_1_0101) begin
            miscompares++;
            $display("FAIL after_bubble obs=%b expected=%b", obs, 15'b0000_0_0_1_0_0_0_1_0101);
        end
    endtask

    task automatic test_nv();
`ifdef SQUASH_CNT_EN
        logic [15:0] before;
        before = SquashCnt;
`endif
        drive(4'hf, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if ({PCSrcE, CondExE} !== 2'b00) begin
            miscompares++;
            $display("FAIL nv_pcsrc got=%b expected=00", {PCSrcE, CondExE});
        end
        drive(4'he, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        tick();
        vectors++;
        if ({PCSrcE, CondExE} !== 2'b11) begin
            miscompares++;
            $display("FAIL al_pcsrc got=%b expected=11", {PCSrcE, CondExE});
        end
`ifdef SQUASH_CNT_EN
        vectors++;
        if (SquashCnt !== before + 16'd1) begin
            miscompares++;
            $display("FAIL nv_squash_inc got=%h expected=%h", SquashCnt, before + 16'd1);
        end
`endif
    endtask

`ifdef SQUASH_CNT_EN
    task automatic test_squash();
        SquashClr = 1'b1;
        drive(4'he, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        tick();
        SquashClr = 1'b0;
        vectors++;
        if (SquashCnt !== 16'd0) begin
            miscompares++;
            $display("FAIL squash_clr got=%h expected=0000", SquashCnt);
        end
        drive(4'hf, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0);
        StallE = 1'b0;
        tick();
        StallE = 1'b1;
        tick();
        tick();
        vectors++;
        if (SquashCnt !== 16'd0) begin
            miscompares++;
            $display("FAIL squash_stall got=%h expected=0000", SquashCnt);
        end
        StallE = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        vectors++;
        if (SquashCnt !== 16'hffff) begin
            miscompares++;
            $display("FAIL squash_sat got=%h expected=ffff", SquashCnt);
        end
        SquashClr = 1'b1;
        tick();
        SquashClr = 1'b0;
        vectors++;
        if (SquashCnt !== 16'd0) begin
            miscompares++;
            $display("FAIL squash_clr_prio got=%h expected=0000", SquashCnt);
        end
    endtask
`endif

    task automatic test_mid_reset();
        drive(4'he, 1, 1, 1, 1, 1, 1, 0, 2'b11, 4'ha);
        ALUFlagsE = 4'b1010;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 15'd0) begin
            miscompares++;
            $display("FAIL mid_reset obs=%b expected=%b", obs, 15'd0);
        end
        #1;
        rst_n = 1'b1;
        drive(4'he, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h6);
        tick();
        vectors++;
        if (obs !== 15'b0110_0_0_0_0_1_0_1_0000) begin
            miscompares++;
            $display("FAIL post_reset_capture obs=%b expected=%b", obs, 15'b0110_0_0_0_0_1_0_1_0000);
        end
    endtask

    initial begin
        test_reset();
        test_eq_ne();
        test_cmp_branch();
        test_cond_table(4'b1000, 16'h6a9a);
        test_cond_table(4'b0110, 16'h66a5);
        test_cond_table(4'b0011, 16'h6966);
        test_partial_flags();
        test_stall_flush();
        test_nv();
`ifdef SQUASH_CNT_EN
        test_squash();
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
